e_mdu: RTL
==========

// Module: e_mdu
// PURPOSE
// - E-stage multiply/divide unit; consumes the operands that leave the ID/EX register (rs/rt values).
// - Produces the busy indication that the hazard logic turns into the ID/EX flush plus the F/D stall.
// - Holds architectural HI/LO and serves mfhi/mflo to the E-stage result mux.
// - Multi-cycle: a result becomes visible in HI/LO only after a fixed latency.
// PARAMETERS
// MULT_CYCLES  5   busy cycles for mult/multu after the start cycle (legal range 1..15)
// DIV_CYCLES   10  busy cycles for div/divu after the start cycle (legal range 1..15)
// PORTS
// clk       in   1   rising-edge clock
// reset     in   1   asynchronous, active-low; clears all state
// start     in   1   one-cycle strobe; the E-stage instruction is an MDU op
// op        in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
// A         in   32  rs value (forwarded)
// B         in   32  rt value (forwarded)
// busy      out  1   operation in flight
// HI_out    out  32  architectural HI
// LO_out    out  32  architectural LO
// rdata     out  32  op==MFHI ? HI_out : LO_out (combinational)
// BEHAVIOUR
// Reset and idle
// - reset low (async): HI_out=0, LO_out=0, busy=0, counter=0, shadow regs=0, state IDLE.
// - reset is sampled low mid-operation: the operation is abandoned; HI/LO do not change after reset releases.
// State machine: IDLE, RUN
// - IDLE & start & op in {0..3}:
//   - compute the 64-bit result into shadow hi/lo;
//   - load counter = MULT_CYCLES or DIV_CYCLES;
//   - go to RUN. busy=1 from the next cycle.
// - RUN: counter decrements each cycle.
//   - When counter==1: HI_out/LO_out <= shadow at that edge, busy=0, return to IDLE.
//   - A new start is accepted the cycle busy drops.
// - start & op MTHI/MTLO in IDLE: HI_out (or LO_out) <= A at that edge; no busy.
// - start in RUN (any op): ignored. Hazard logic guarantees this never happens; the bench checks it is harmless.
// - MFHI/MFLO: no state change; rdata is valid the same cycle and reflects committed HI/LO only.
// Arithmetic
// - MULT: {HI,LO} = $signed(A) * $signed(B), 64-bit.
// - MULTU: {HI,LO} = unsigned product, 64-bit.
// - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
// - DIVU: unsigned quotient and remainder.
// - DIV with B==0: HI/LO are unchanged. busy still runs DIV_CYCLES so timing is data-independent.
// - DIV with A==0x80000000, B==-1: LO=0x80000000, HI=0 (wraps, no trap).
// Hazard contract
// - The stall unit stalls when (start | busy) and the D-stage op is an MDU op.
// - busy is a registered output; it does not depend combinationally on start.
// TESTING
// - reset low mid-run -> busy=0 and HI=LO=0 immediately.
// - MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
// - MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
// - DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. rdata(MFHI) keeps the old HI during busy.
// - DIV B=0 with HI=0x11, LO=0x22 -> busy 10 cycles; HI/LO stay 0x11/0x22.
// - MTHI A=0x1234 then start MULT while busy -> HI=0x1234 at once; the second start is ignored and the busy length is unchanged.

Source files
------------

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div with architectural HI/LO,
// mthi/mtlo writes and a combinational mfhi/mflo read port.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] rdata,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;

  // Handshake: start is a one-cycle strobe accepted only in IDLE; busy is
  // registered, high from the cycle after acceptance until the commit edge.
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] sh_hi, sh_lo;
  logic        sh_commit;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_a, div_b;
  logic [31:0] uq, ur, sq, sr;
  logic        b_zero;

  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'b0, A} * {32'b0, B};
    b_zero = (B == 32'd0);
    abs_a  = A[31] ? (~A + 32'd1) : A;
    abs_b  = B[31] ? (~B + 32'd1) : B;
    // Divisor forced to 1 when zero; that result is never committed anyway.
    div_a  = (op == OP_DIV) ? abs_a : A;
    div_b  = b_zero ? 32'd1 : ((op == OP_DIV) ? abs_b : B);
    uq     = div_a / div_b;
    ur     = div_a % div_b;
    // Magnitude-based signed divide: 0x80000000 / -1 wraps cleanly.
    sq     = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
    sr     = A[31] ? (~ur + 32'd1) : ur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      sh_hi     <= 32'd0;
      sh_lo     <= 32'd0;
      sh_commit <= 1'b0;
      HI_out    <= 32'd0;
      LO_out    <= 32'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {sh_hi, sh_lo} <= (op == OP_MULT) ? prod_s : prod_u;
                sh_commit      <= 1'b1;
                cnt            <= 4'(MULT_CYCLES);
                busy           <= 1'b1;
                state          <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                sh_hi     <= (op == OP_DIV) ? sr : ur;
                sh_lo     <= (op == OP_DIV) ? sq : uq;
                sh_commit <= !b_zero;
                cnt       <= 4'(DIV_CYCLES);
                busy      <= 1'b1;
                state     <= RUN;
              end
              OP_MTHI: HI_out <= A;
              OP_MTLO: LO_out <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == 4'd1) begin
            if (sh_commit) begin
              HI_out <= sh_hi;
              LO_out <= sh_lo;
            end
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rdata     = (op == OP_MFHI) ? HI_out : LO_out;
  assign dbg_state = state;

endmodule
